// File: rtl/frv_mem_arbiter.sv
// frv_mem_arbiter: two-port (instruction / data) to one-bus memory arbiter.
//
// Ports
//   g_clk, g_resetn         clock, asynchronous active-low reset
//   imem_*                  port 0 request (req/wen/strb/addr/wdata -> gnt) and
//                           response (recv/error/rdata <- ack)
//   dmem_*                  port 1, identical to port 0
//   bus_*                   shared downstream request and response channels
//   arb_error               sticky flag: a bus response arrived with nothing outstanding
//
// Requests are selected round-robin and stay locked while the bus stalls.
// Each grant records its port id in an owner FIFO so responses are routed back
// in grant order. Request and response paths are purely combinational.
module frv_mem_arbiter #(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned XL          = 31
) (
  input  logic          g_clk,
  input  logic          g_resetn,

  input  logic          imem_req,
  input  logic          imem_wen,
  input  logic [3:0]    imem_strb,
  input  logic [XL:0]   imem_addr,
  input  logic [XL:0]   imem_wdata,
  output logic          imem_gnt,
  output logic          imem_recv,
  input  logic          imem_ack,
  output logic          imem_error,
  output logic [XL:0]   imem_rdata,

  input  logic          dmem_req,
  input  logic          dmem_wen,
  input  logic [3:0]    dmem_strb,
  input  logic [XL:0]   dmem_addr,
  input  logic [XL:0]   dmem_wdata,
  output logic          dmem_gnt,
  output logic          dmem_recv,
  input  logic          dmem_ack,
  output logic          dmem_error,
  output logic [XL:0]   dmem_rdata,

  output logic          bus_req,
  output logic          bus_wen,
  output logic [3:0]    bus_strb,
  output logic [XL:0]   bus_addr,
  output logic [XL:0]   bus_wdata,
  input  logic          bus_gnt,
  input  logic          bus_recv,
  output logic          bus_ack,
  input  logic          bus_error,
  input  logic [XL:0]   bus_rdata,

  output logic          arb_error
);

  localparam int unsigned PtrW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned Slots = 1 << PtrW;
  localparam int unsigned CntW  = $clog2(OUTSTANDING + 1);

  typedef enum logic [0:0] {StOpen, StHold} state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic [Slots-1:0]  owner_q, owner_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              arb_error_q, arb_error_d;

  logic sel;
  logic sel_req;
  logic full;
  logic empty;
  logic head;
  logic push;
  logic pop;

  // Port selection: locked while stalled, otherwise round-robin on a tie.
  always_comb begin
    sel = sel_q;
    if (state_q == StOpen) begin
      case ({dmem_req, imem_req})
        2'b01:   sel = 1'b0;
        2'b10:   sel = 1'b1;
        2'b11:   sel = ~last_q;
        default: sel = sel_q;
      endcase
    end
  end

  assign full    = (count_q == CntW'(OUTSTANDING));
  assign empty   = (count_q == '0);
  assign head    = owner_q[rd_ptr_q];
  assign sel_req = sel ? dmem_req : imem_req;

  // Gated by reset so no grant can leak out while the block is held in reset.
  assign bus_req   = sel_req & ~full & g_resetn;
  assign bus_wen   = sel ? dmem_wen   : imem_wen;
  assign bus_strb  = sel ? dmem_strb  : imem_strb;
  assign bus_addr  = sel ? dmem_addr  : imem_addr;
  assign bus_wdata = sel ? dmem_wdata : imem_wdata;

  assign imem_gnt = bus_gnt & bus_req & ~sel;
  assign dmem_gnt = bus_gnt & bus_req &  sel;
  assign push     = bus_req & bus_gnt;

  assign imem_recv  = bus_recv & ~empty & ~head;
  assign dmem_recv  = bus_recv & ~empty &  head;
  assign imem_rdata = bus_rdata;
  assign dmem_rdata = bus_rdata;
  assign imem_error = bus_error;
  assign dmem_error = bus_error;

  // A response with no owner is acknowledged immediately so the bus cannot hang.
  assign bus_ack = empty ? bus_recv : (head ? dmem_ack : imem_ack);
  assign pop     = bus_recv & bus_ack & ~empty;

  assign arb_error = arb_error_q;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel;
    last_d      = last_q;
    owner_d     = owner_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    arb_error_d = arb_error_q | (bus_recv & empty);

    case (state_q)
      StOpen:  if (bus_req && !bus_gnt) state_d = StHold;
      StHold:  if (bus_req &&  bus_gnt) state_d = StOpen;
      default: state_d = StOpen;
    endcase

    if (push) begin
      owner_d[wr_ptr_q] = sel;
      wr_ptr_d          = wr_ptr_q + 1'b1;
      last_d            = sel;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= StOpen;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      owner_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      arb_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      arb_error_q <= arb_error_d;
    end
  end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Testbench for frv_mem_arbiter: directed scenarios followed by a randomized
// phase checked against a transaction-level model (owner queue, per-port
// expected-response queues and a simple in-order downstream memory).
module tb_frv_mem_arbiter;

  localparam int unsigned OUTST = 2;
  localparam int unsigned XL    = 31;

  logic        g_clk, g_resetn;
  logic        imem_req, imem_wen, imem_gnt, imem_recv, imem_ack, imem_error;
  logic [3:0]  imem_strb;
  logic [31:0] imem_addr, imem_wdata, imem_rdata;
  logic        dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_ack, dmem_error;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        bus_req, bus_wen, bus_gnt, bus_recv, bus_ack, bus_error;
  logic [3:0]  bus_strb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        arb_error;

  frv_mem_arbiter #(.OUTSTANDING(OUTST), .XL(XL)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_gnt(imem_gnt),
    .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
    .dmem_rdata(dmem_rdata),
    .bus_req(bus_req), .bus_wen(bus_wen), .bus_strb(bus_strb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_recv(bus_recv), .bus_ack(bus_ack),
    .bus_error(bus_error), .bus_rdata(bus_rdata),
    .arb_error(arb_error)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_last, m_held;
  int          owners[$];
  logic [31:0] iq[$], dq[$], mq[$];
  int          e_sel, e_head;
  bit          e_breq, e_ig, e_dg, e_ir, e_dr, e_ack, e_pop, e_push;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5a5a_0f0f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1;
    m_held = -1;
    owners.delete();
    iq.delete();
    dq.delete();
    mq.delete();
  endtask

  task automatic drive_idle();
    imem_req = 0; imem_wen = 0; imem_strb = 4'h0; imem_addr = '0; imem_wdata = '0;
    imem_ack = 0;
    dmem_req = 0; dmem_wen = 0; dmem_strb = 4'h0; dmem_addr = '0; dmem_wdata = '0;
    dmem_ack = 0;
    bus_gnt = 0; bus_recv = 0; bus_error = 0; bus_rdata = '0;
  endtask

  // Called one time unit after a rising edge with inputs already driven.
  task automatic eval();
    bit full, empty;
    #1;
    full  = (owners.size() == OUTST);
    empty = (owners.size() == 0);
    if (m_held >= 0)                e_sel = m_held;
    else if (imem_req && dmem_req)  e_sel = 1 - m_last;
    else if (imem_req)              e_sel = 0;
    else if (dmem_req)              e_sel = 1;
    else                            e_sel = -1;
    e_breq = !full && ((e_sel == 0 && imem_req) || (e_sel == 1 && dmem_req));
    e_ig   = e_breq && bus_gnt && (e_sel == 0);
    e_dg   = e_breq && bus_gnt && (e_sel == 1);
    e_head = empty ? -1 : owners[0];
    e_ir   = bus_recv && (e_head == 0);
    e_dr   = bus_recv && (e_head == 1);
    e_ack  = empty ? bus_recv : ((e_head == 0) ? imem_ack : dmem_ack);
    e_pop  = bus_recv && e_ack && !empty;
    e_push = e_breq && bus_gnt;

    check("bus_req",   32'(bus_req),   32'(e_breq));
    check("imem_gnt",  32'(imem_gnt),  32'(e_ig));
    check("dmem_gnt",  32'(dmem_gnt),  32'(e_dg));
    check("imem_recv", 32'(imem_recv), 32'(e_ir));
    check("dmem_recv", 32'(dmem_recv), 32'(e_dr));
    check("bus_ack",   32'(bus_ack),   32'(e_ack));
    if (e_breq) begin
      check("bus_addr",  bus_addr,  (e_sel == 0) ? imem_addr : dmem_addr);
      check("bus_wdata", bus_wdata, (e_sel == 0) ? imem_wdata : dmem_wdata);
      check("bus_ctrl", {27'b0, bus_wen, bus_strb},
            (e_sel == 0) ? {27'b0, imem_wen, imem_strb} : {27'b0, dmem_wen, dmem_strb});
    end
    if (bus_recv) begin
      check("imem_rdata_fwd", imem_rdata, bus_rdata);
      check("dmem_rdata_fwd", dmem_rdata, bus_rdata);
      check("error_fwd", {30'b0, imem_error, dmem_error}, {30'b0, bus_error, bus_error});
    end
  endtask

  task automatic adv();
    if (e_pop) void'(owners.pop_front());
    if (e_push) begin
      owners.push_back(e_sel);
      m_last = e_sel;
      m_held = -1;
    end else if (e_breq) begin
      m_held = e_sel;
    end
    @(posedge g_clk);
    #1;
  endtask

  bit resp_active;

  initial begin
    drive_idle();
    model_reset();
    g_resetn = 0;

    // Reset state: nothing granted or routed whatever the bus does.
    @(posedge g_clk); #1;
    imem_req = 1; dmem_req = 1; bus_gnt = 1; bus_recv = 1;
    #1;
    check("rst_bus_req",   32'(bus_req),   32'd0);
    check("rst_imem_gnt",  32'(imem_gnt),  32'd0);
    check("rst_dmem_gnt",  32'(dmem_gnt),  32'd0);
    check("rst_imem_recv", 32'(imem_recv), 32'd0);
    check("rst_dmem_recv", 32'(dmem_recv), 32'd0);
    @(posedge g_clk); #1;
    check("rst_arb_error", 32'(arb_error), 32'd0);
    drive_idle();
    @(negedge g_clk) g_resetn = 1;
    @(posedge g_clk); #1;

    // Spurious response: acked, not routed, sticky error until reset.
    bus_recv = 1; bus_rdata = 32'hdead_beef;
    eval();
    check("spur_bus_ack", 32'(bus_ack), 32'd1);
    adv();
    bus_recv = 0;
    #1 check("spur_arb_error", 32'(arb_error), 32'd1);
    repeat (3) @(posedge g_clk);
    #1 check("spur_sticky", 32'(arb_error), 32'd1);
    #1 g_resetn = 0;
    #1 check("spur_cleared", 32'(arb_error), 32'd0);
    model_reset();
    @(negedge g_clk) g_resetn = 1;
    @(posedge g_clk); #1;

    // Round-robin with both ports requesting; port 0 wins the first tie.
    imem_req = 1; imem_addr = 32'h1000; dmem_req = 1; dmem_addr = 32'h2000; bus_gnt = 1;
    eval();
    check("rr_first_imem", 32'(imem_gnt), 32'd1);
    check("rr_first_addr", bus_addr, 32'h1000);
    adv();
    imem_addr = 32'h1004;
    eval();
    check("rr_second_dmem", 32'(dmem_gnt), 32'd1);
    check("rr_second_addr", bus_addr, 32'h2000);
    adv();

    // Full: no request even though a pop happens this cycle.
    bus_recv = 1; bus_rdata = 32'h11; imem_ack = 1;
    eval();
    check("full_bus_req", 32'(bus_req), 32'd0);
    check("full_imem_recv", 32'(imem_recv), 32'd1);
    check("resp1_rdata", imem_rdata, 32'h11);
    adv();

    // Next cycle after the pop the pending request is granted; dmem stalls its ack.
    bus_rdata = 32'h22; imem_ack = 0; dmem_ack = 0;
    eval();
    check("after_pop_gnt", 32'(imem_gnt), 32'd1);
    check("stall1_bus_ack", 32'(bus_ack), 32'd0);
    adv();
    imem_req = 0; dmem_req = 0;
    eval();
    check("stall2_bus_ack", 32'(bus_ack), 32'd0);
    adv();
    dmem_ack = 1;
    eval();
    check("resp2_dmem_recv", 32'(dmem_recv), 32'd1);
    check("resp2_rdata", dmem_rdata, 32'h22);
    adv();

    // Stalled dmem request stays on the bus while imem joins.
    bus_recv = 0; dmem_ack = 0; bus_gnt = 0; dmem_req = 1; dmem_addr = 32'h8000_0010;
    eval();
    adv();
    imem_req = 1; imem_addr = 32'h3000;
    for (int i = 0; i < 2; i++) begin
      eval();
      check("hold_addr", bus_addr, 32'h8000_0010);
      adv();
    end
    bus_gnt = 1;
    eval();
    check("hold_dmem_gnt", 32'(dmem_gnt), 32'd1);
    adv();
    dmem_req = 0; bus_recv = 1; bus_rdata = 32'h33; imem_ack = 1;
    eval();
    adv();
    imem_ack = 0; dmem_ack = 1; bus_rdata = 32'h44;
    eval();
    check("imem_next_gnt", 32'(imem_gnt), 32'd1);
    check("resp4_rdata", dmem_rdata, 32'h44);
    adv();

    // Two outstanding, then asynchronous reset mid-cycle.
    imem_req = 0; bus_recv = 0; dmem_ack = 0; dmem_req = 1; dmem_addr = 32'h4000;
    eval();
    adv();
    imem_req = 1; dmem_req = 1; bus_gnt = 1; bus_recv = 1; imem_ack = 0;
    eval();
    check("pre_rst_imem_recv", 32'(imem_recv), 32'd1);
    #1 g_resetn = 0;
    #1;
    check("arst_imem_gnt",  32'(imem_gnt),  32'd0);
    check("arst_dmem_gnt",  32'(dmem_gnt),  32'd0);
    check("arst_bus_req",   32'(bus_req),   32'd0);
    check("arst_imem_recv", 32'(imem_recv), 32'd0);
    check("arst_dmem_recv", 32'(dmem_recv), 32'd0);
    model_reset();
    drive_idle();
    @(negedge g_clk) g_resetn = 1;
    @(posedge g_clk); #1;

    // After reset the first tie again goes to imem.
    imem_req = 1; imem_addr = 32'h5000; dmem_req = 1; dmem_addr = 32'h6000; bus_gnt = 0;
    eval();
    check("post_rst_sel", bus_addr, 32'h5000);
    adv();

    // Randomized traffic against the transaction model.
    resp_active = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!imem_req && $urandom_range(0, 1) == 1) begin
        imem_req = 1; imem_addr = $urandom; imem_wdata = $urandom;
        imem_wen = 1'($urandom); imem_strb = 4'($urandom);
      end
      if (!dmem_req && $urandom_range(0, 1) == 1) begin
        dmem_req = 1; dmem_addr = $urandom; dmem_wdata = $urandom;
        dmem_wen = 1'($urandom); dmem_strb = 4'($urandom);
      end
      bus_gnt = ($urandom_range(0, 3) != 0);
      if (!resp_active && mq.size() != 0 && $urandom_range(0, 1) == 1) begin
        resp_active = 1;
        bus_rdata   = mem_data(mq[0]);
        bus_error   = 1'($urandom);
      end
      if (!resp_active) bus_rdata = $urandom;
      bus_recv = resp_active;
      imem_ack = ($urandom_range(0, 3) != 0);
      dmem_ack = ($urandom_range(0, 3) != 0);
      eval();
      if (e_ir && imem_ack) begin
        if (iq.size() == 0) begin
          checks++; errors++;
          $error("FAIL imem_unexpected_resp observed=%0h expected=none", imem_rdata);
        end else check("imem_order", imem_rdata, mem_data(iq.pop_front()));
      end
      if (e_dr && dmem_ack) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $error("FAIL dmem_unexpected_resp observed=%0h expected=none", dmem_rdata);
        end else check("dmem_order", dmem_rdata, mem_data(dq.pop_front()));
      end
      if (e_pop) begin
        void'(mq.pop_front());
        resp_active = 0;
      end
      if (e_ig) begin iq.push_back(imem_addr); mq.push_back(imem_addr); end
      if (e_dg) begin dq.push_back(dmem_addr); mq.push_back(dmem_addr); end
      adv();
      if (e_ig) imem_req = 0;
      if (e_dg) dmem_req = 0;
    end
    check("rand_arb_error", 32'(arb_error), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
